// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor I/O port sequencer.
// Control-word bit positions match the datapath's coprocessorIOControl decode.
package coproc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam int CP_WE   = 0;
   localparam int CP_CSR  = 3;
   localparam int CP_HOLD = 4;

   localparam int CTRL_W     = 5;
   localparam int CP_ADDR_W  = 15;
   localparam int REQ_ADDR_W = 12;
   localparam int REG_IDX_W  = 5;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr_q, ptr_d;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // On a tie the requester that did not win last time goes first
         2'b11:   grant = ptr_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
      ptr_d = ptr_q;
      if (advance && (grant != 2'b00)) ptr_d = grant[1];
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= 1'b1;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/coproc_access_ctrl.sv
// Arbitrates debug-host and fault-handler register/CSR accesses onto the datapath
// coprocessor port, holding the core for exactly two cycles around each access.
module coproc_access_ctrl
   import coproc_pkg::*;
#(
   parameter int N = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 req_valid,
   output logic [1:0]                 req_ready,
   input  logic [1:0]                 req_write,
   input  logic [1:0]                 req_csr,
   input  logic [1:0][REQ_ADDR_W-1:0] req_addr,
   input  logic [1:0][N-1:0]          req_wdata,
   output logic [1:0]                 resp_valid,
   output logic                       resp_err,
   output logic [N-1:0]               resp_rdata,
   output logic [CP_ADDR_W-1:0]       coprocessorIOAddr,
   output logic [CTRL_W-1:0]          coprocessorIOControl,
   output logic [N-1:0]               coprocessorIODataOut,
   input  logic [N-1:0]               coprocessorIODataIn,
   output logic                       busy
);

   state_e state_q, state_d;

   logic [1:0] grant;
   logic       accept;
   logic       win;

   logic                  owner_q, owner_d;
   logic                  write_q, write_d;
   logic                  csr_q, csr_d;
   logic [REQ_ADDR_W-1:0] addr_q, addr_d;
   logic [N-1:0]          wdata_q, wdata_d;

   logic [CP_ADDR_W-1:0] cp_addr_q, cp_addr_d;
   logic [CTRL_W-1:0]    cp_ctrl_q, cp_ctrl_d;
   logic [N-1:0]         cp_dout_q, cp_dout_d;
   logic [1:0]           resp_valid_q, resp_valid_d;
   logic                 resp_err_q, resp_err_d;
   logic [N-1:0]         resp_rdata_q, resp_rdata_d;
   logic                 busy_q, busy_d;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .advance (accept),
      .grant   (grant)
   );

   assign req_ready = ((state_q == IDLE) && !reset) ? grant : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign win       = req_ready[1];

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      write_d      = write_q;
      csr_d        = csr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cp_addr_d    = '0;
      cp_ctrl_d    = '0;
      cp_dout_d    = '0;
      resp_valid_d = 2'b00;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;

      // Outputs are registered, so each branch sets what the next state drives
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d            = HOLD;
               owner_d            = win;
               write_d            = req_write[win];
               csr_d              = req_csr[win];
               addr_d             = req_addr[win];
               wdata_d            = req_wdata[win];
               cp_ctrl_d[CP_HOLD] = 1'b1;
               cp_addr_d          = {{(CP_ADDR_W-REQ_ADDR_W){1'b0}}, req_addr[win]};
            end
         end
         HOLD: begin
            state_d            = ACCESS;
            cp_ctrl_d[CP_HOLD] = 1'b1;
            cp_ctrl_d[CP_CSR]  = csr_q & ~write_q;
            // CSR writes are refused: no strobe, flagged as an error in RESP
            cp_ctrl_d[CP_WE]   = write_q & ~csr_q;
            cp_addr_d          = {{(CP_ADDR_W-REQ_ADDR_W){1'b0}}, addr_q};
            cp_dout_d          = (write_q & ~csr_q) ? wdata_q : '0;
         end
         ACCESS: begin
            state_d               = RESP;
            resp_valid_d[owner_q] = 1'b1;
            resp_err_d            = write_q & csr_q;
            resp_rdata_d          = write_q ? '0 : coprocessorIODataIn;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cp_addr_q    <= '0;
         cp_ctrl_q    <= '0;
         cp_dout_q    <= '0;
         resp_valid_q <= 2'b00;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cp_addr_q    <= cp_addr_d;
         cp_ctrl_q    <= cp_ctrl_d;
         cp_dout_q    <= cp_dout_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         busy_q       <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      owner_q <= owner_d;
      write_q <= write_d;
      csr_q   <= csr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

   assign coprocessorIOAddr    = cp_addr_q;
   assign coprocessorIOControl = cp_ctrl_q;
   assign coprocessorIODataOut = cp_dout_q;
   assign resp_valid           = resp_valid_q;
   assign resp_err             = resp_err_q;
   assign resp_rdata           = resp_rdata_q;
   assign busy                 = busy_q;

endmodule

// File: doc/coproc_access_ctrl.md
# coproc_access_ctrl

Sequencer and arbiter for the datapath's coprocessor I/O port: accepts register/CSR access requests from two requesters (0 = debug host, 1 = TMR fault handler), grants them round-robin, freezes the core while an access is in flight, and returns read data. It sits between the requesters and the `coprocessorIOAddr` / `coprocessorIOControl` / `coprocessorIODataOut` / `coprocessorIODataIn` pins of `datapath`. Any nonzero `coprocessorIOControl` stalls the PC, so this block is the only legal driver of those pins.

## Interface
- `N`, 64, datapath/register width

- `clk`  in  1  clock; single clock domain
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  2  per-requester request strobe
- `req_ready`  out  2  per-requester accept; a request is accepted when `req_valid[i] & req_ready[i]`
- `req_write`  in  2  1 = write, 0 = read
- `req_csr`  in  2  1 = CSR space, 0 = integer register file
- `req_addr`  in  2×12  CSR address, or register index in `[4:0]`
- `req_wdata`  in  2×N  write data
- `resp_valid`  out  2  one-cycle response pulse to the owning requester
- `resp_err`  out  1  qualifies `resp_valid`; 1 = request rejected
- `resp_rdata`  out  N  read data, valid with `resp_valid`
- `coprocessorIOAddr`  out  15  `[11:0]` = address, `[14:12]` = 0
- `coprocessorIOControl`  out  5  bit0 = reg write enable, bit3 = CSR select, bit4 = hold; bits 1–2 are always 0
- `coprocessorIODataOut`  out  N  register write data
- `coprocessorIODataIn`  in  N  read data from the register file or CSR
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, HOLD, ACCESS, RESP.
- **IDLE**
  - `req_ready` is one-hot to the arbitration winner, and only when that requester has `req_valid` high.
  - On accept, latch the owner, write, csr, addr and wdata, then go to HOLD.
- **Round-robin arbitration**
  - The pointer holds the last granted requester and resets to 1, so requester 0 wins the first tie.
  - A lone request is always granted.
  - On simultaneous requests, the requester other than the last granted one wins.
- **HOLD** (one cycle)
  - Control = `5'b10000` and the address is driven, freezing the PC before any access.
  - Go to ACCESS.
- **ACCESS** (one cycle)
  - Reg read: control = `5'b10000`. Sample `coprocessorIODataIn` at the end of the cycle.
  - CSR read: control = `5'b11000`. Sample as for a reg read.
  - Reg write: control = `5'b10001`, with `coprocessorIODataOut` = the latched wdata.
  - CSR write is unsupported. Control stays `5'b10000`, no write strobe is issued, and the error flag is set.
  - Go to RESP.
- **RESP** (one cycle)
  - Control = 0, so the core executes one instruction. This guarantees forward progress between back-to-back accesses.
  - Pulse `resp_valid[owner]`. Reads return the sampled data. Writes and errors return `resp_rdata` = 0.
  - Go to IDLE.
- Writes to x0 are issued normally (the register file discards them) and get `resp_err` = 0.
- Request inputs are ignored outside IDLE. There is no response backpressure.

## Timing
- **Reset** (synchronous)
  - Applies at the next edge: state = IDLE, arbitration pointer = 1.
  - All outputs go to 0: `coprocessorIOAddr`, `coprocessorIOControl`, `coprocessorIODataOut`, `req_ready`, `resp_valid`, `resp_err`, `resp_rdata`, `busy`.
  - Reset mid-transaction drops the transaction with no response. A write whose ACCESS cycle has not yet occurred is not performed.
- **Latency**
  - Accept at cycle T; HOLD at T+1; ACCESS at T+2; `resp_valid` at T+3.
  - The next accept is possible at T+4, so sustained throughput is one access per 4 cycles.
  - The core is stalled for exactly 2 cycles per access.
- All outputs are registered, except `req_ready`, which is a combinational function of state, pointer and `req_valid`.
- `busy` rises at T+1 and falls at T+4.

## Structure
- Package `coproc_pkg`:
  - state enum (`IDLE`, `HOLD`, `ACCESS`, `RESP`)
  - control bit index constants (`CP_WE`=0, `CP_CSR`=3, `CP_HOLD`=4)
  - address field widths
- Sub-module `rr_arbiter2`: 2-way round-robin arbiter with pointer register, `grant` output, and an `advance` input pulsed on accept.

## Test plan
- **Reset, then idle:** reset high for 2 cycles, then low with no requests → all outputs 0 and `busy` = 0 for 10 cycles.
- **Register write then read:**
  - Requester 0 writes x5 = 0xDEAD_BEEF_0000_0001 → control `5'b10001` with addr 5 only at T+2; `resp_valid[0]` at T+3.
  - Requester 0 then reads x5 → `resp_rdata` = 0xDEAD_BEEF_0000_0001.
- **CSR read:** requester 1 reads CSR 0x341 → control `5'b11000` at ACCESS, addr = 0x341, `resp_rdata` = the CSR model value, `resp_err` = 0.
- **CSR write rejected:** requester 0 writes CSR 0x300 → no cycle with bit0 set; `resp_err` = 1; `resp_rdata` = 0.
- **Simultaneous requests:** both requesters hold `req_valid` continuously after reset → grants alternate 0,1,0,1; accepts are 4 cycles apart; control = 0 in every RESP cycle.
- **Reset mid-write:** reset asserted during HOLD of a write → no control bit0 ever seen, no `resp_valid`, outputs 0 the next cycle, and a subsequent request completes normally.
